weight_tile_loader: RTL and testbench

Upstream feeder for the weight FIFO. Accepts weight rows (one PE row of `MATRIX_SIZE` weights per beat) over a valid/ready stream and packs `NUM_PE_ROWS` rows into one full tile word. It writes each completed tile into the weight FIFO with a one-cycle `write_enable` pulse. The FIFO has no full flag and drops writes when full, so this block keeps a credit counter mirroring FIFO occupancy and never overflows it.

---
 rtl/weight_pkg.sv | 22 ++
 rtl/weight_tile_loader_if.sv | 13 +
 rtl/credit_counter.sv | 26 ++
 rtl/weight_tile_loader.sv | 104 ++++++++++
 tb/tb_weight_tile_loader.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/weight_pkg.sv
// rtl/weight_pkg.sv - shared widths, FSM state type and credit width helper for the weight tile loader
package weight_pkg;

    localparam int DEF_WEIGHT_BW   = 8;
    localparam int DEF_NUM_PE_ROWS = 8;
    localparam int DEF_MATRIX_SIZE = 8;
    localparam int DEF_FIFO_DEPTH  = 4;

    localparam int ROW_W  = DEF_WEIGHT_BW * DEF_MATRIX_SIZE;
    localparam int TILE_W = ROW_W * DEF_NUM_PE_ROWS;

    typedef enum logic {
        FILL   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    // Counter must hold 0..depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/weight_tile_loader_if.sv
// rtl/weight_tile_loader_if.sv - row beat stream into the weight tile loader
interface weight_tile_loader_if #(
    parameter int ROW_W = weight_pkg::ROW_W
);
    logic             in_valid;
    logic             in_ready;
    logic [ROW_W-1:0] in_row;
    logic             in_last;

    modport master (output in_valid, output in_row, output in_last, input in_ready);
    modport slave  (input in_valid, input in_row, input in_last, output in_ready);

endinterface

// File: rtl/credit_counter.sv
// rtl/credit_counter.sv - saturating up/down counter, resets to MAX; reusable for FIFO feeders
module credit_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    // Simultaneous inc and dec cancel; each direction saturates on its own bound.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= MAX_C;
        end else if (inc && !dec && count < MAX_C) begin
            count <= count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/weight_tile_loader.sv
// rtl/weight_tile_loader.sv - packs row beats into tiles and writes them to a credit-tracked FIFO; option WEIGHT_TILE_LOADER_PARTIAL_EN
module weight_tile_loader
    import weight_pkg::*;
#(
    parameter int WEIGHT_BW   = DEF_WEIGHT_BW,
    parameter int NUM_PE_ROWS = DEF_NUM_PE_ROWS,
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                                          clk,
    input  logic                                          rst,
    weight_tile_loader_if.slave                           row_in,
    input  logic                                          fifo_rd,
    output logic                                          fifo_wr_en,
    output logic [WEIGHT_BW*NUM_PE_ROWS*MATRIX_SIZE-1:0]  fifo_data,
    output logic [credit_width(FIFO_DEPTH)-1:0]           credits,
    output logic [15:0]                                   tiles_written
);

    localparam int ROW_BITS  = WEIGHT_BW * MATRIX_SIZE;
    localparam int TILE_BITS = ROW_BITS * NUM_PE_ROWS;
    localparam int RC_W      = (NUM_PE_ROWS > 1) ? $clog2(NUM_PE_ROWS) : 1;
    localparam logic [RC_W-1:0] LAST_IDX = RC_W'(NUM_PE_ROWS - 1);

    state_t              state;
    state_t              state_n;
    logic [RC_W-1:0]     row_cnt;
    logic [TILE_BITS-1:0] tile;
    logic                accept;
    logic                tile_done;
    logic                ready_c;
    logic                wr_c;

    assign accept = row_in.in_valid & (state == FILL);

`ifdef WEIGHT_TILE_LOADER_PARTIAL_EN
    // Unfilled rows are already zero because the tile clears on every commit.
    assign tile_done = accept & ((row_cnt == LAST_IDX) | row_in.in_last);
`else
    logic unused_last;
    assign unused_last = row_in.in_last;
    assign tile_done   = accept & (row_cnt == LAST_IDX);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_n;
        end
    end

    // Write depends only on registered state and credits, never on fifo_rd directly.
    always_comb begin
        state_n = state;
        ready_c = 1'b0;
        wr_c    = 1'b0;
        case (state)
            FILL: begin
                ready_c = 1'b1;
                if (tile_done) begin
                    state_n = COMMIT;
                end
            end
            COMMIT: begin
                if (credits != '0) begin
                    wr_c    = 1'b1;
                    state_n = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile          <= '0;
            row_cnt       <= '0;
            tiles_written <= '0;
        end else if (wr_c) begin
            tile          <= '0;
            tiles_written <= tiles_written + 16'd1;
        end else if (accept) begin
            tile[row_cnt*ROW_BITS +: ROW_BITS] <= row_in.in_row;
            row_cnt <= tile_done ? '0 : row_cnt + 1'b1;
        end
    end

    credit_counter #(
        .MAX (FIFO_DEPTH),
        .W   (credit_width(FIFO_DEPTH))
    ) u_credits (
        .clk   (clk),
        .rst   (rst),
        .inc   (fifo_rd),
        .dec   (wr_c),
        .count (credits)
    );

    assign row_in.in_ready = ready_c;
    assign fifo_wr_en      = wr_c;
    assign fifo_data       = tile;

endmodule

// File: tb/tb_weight_tile_loader.sv
// tb/tb_weight_tile_loader.sv - directed self-checking bench for weight_tile_loader
module tb_weight_tile_loader;

    logic         clk;
    logic         rst;
    logic         fifo_rd;
    logic         fifo_wr_en;
    logic [511:0] fifo_data;
    logic [2:0]   credits;
    logic [15:0]  tiles_written;

    int           total;
    int           bad;
    int           wr_count;
    logic [511:0] last_data;

    weight_tile_loader_if #(.ROW_W(64)) row_if ();

    weight_tile_loader dut (
        .clk           (clk),
        .rst           (rst),
        .row_in        (row_if),
        .fifo_rd       (fifo_rd),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_data     (fifo_data),
        .credits       (credits),
        .tiles_written (tiles_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) begin
            wr_count++;
            last_data = fifo_data;
        end
    end

    function automatic logic [511:0] exp_tile(input int n);
        logic [511:0] t;
        logic [7:0]   b;
        t = '0;
        for (int r = 0; r < n; r++) begin
            b = 8'h10 + 8'(r);
            t[r*64 +: 64] = {8{b}};
        end
        return t;
    endfunction

    task automatic send_row(input int r, input bit last);
        int         waitc;
        logic [7:0] b;
        @(negedge clk);
        b = 8'h10 + 8'(r);
        row_if.in_valid = 1'b1;
        row_if.in_row   = {8{b}};
        row_if.in_last  = last;
        waitc = 0;
        while (row_if.in_ready !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (row_if.in_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL send_row_%0d: in_ready got %b want 1 within 50 cycles", r, row_if.in_ready);
        end else begin
            @(posedge clk);
            #1;
        end
        row_if.in_valid = 1'b0;
        row_if.in_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        row_if.in_valid = 1'b0;
        row_if.in_row   = '0;
        row_if.in_last  = 1'b0;
        fifo_rd = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (row_if.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", row_if.in_ready); end
        total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
        total++; if (fifo_data !== 512'd0) begin bad++; $display("FAIL reset_data: got %h want 0", fifo_data); end
        total++; if (credits !== 3'd4) begin bad++; $display("FAIL reset_credits: got %0d want 4", credits); end
        total++; if (tiles_written !== 16'd0) begin bad++; $display("FAIL reset_tiles: got %0d want 0", tiles_written); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (row_if.in_ready !== 1'b1 || credits !== 3'd4) begin bad++; $display("FAIL post_reset: in_ready %b credits %0d want 1 and 4", row_if.in_ready, credits); end
    endtask

    task automatic test_single_tile();
        int base;
        base = wr_count;
        for (int r = 0; r < 8; r++) send_row(r, 1'b0);
        @(negedge clk);
        total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL single_wr_latency: got %b want 1", fifo_wr_en); end
        total++; if (fifo_data !== exp_tile(8)) begin bad++; $display("FAIL single_data: got %h want %h", fifo_data, exp_tile(8)); end
        total++; if (credits !== 3'd4) begin bad++; $display("FAIL single_credits_pre: got %0d want 4", credits); end
        @(negedge clk); #1;
        total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL single_wr_one_cycle: got %b want 0", fifo_wr_en); end
        total++; if (credits !== 3'd3) begin bad++; $display("FAIL single_credits: got %0d want 3", credits); end
        total++; if (tiles_written !== 16'd1) begin bad++; $display("FAIL single_tiles: got %0d want 1", tiles_written); end
        total++; if (wr_count - base !== 1) begin bad++; $display("FAIL single_wr_count: got %0d want 1", wr_count - base); end
        total++; if (fifo_data !== 512'd0) begin bad++; $display("FAIL single_cleared: got %h want 0", fifo_data); end
    endtask

    task automatic test_credit_stall();
        int           base;
        logic [511:0] snap;
        do_reset();
        base = wr_count;
        for (int t = 0; t < 5; t++)
            for (int r = 0; r < 8; r++) send_row(r, 1'b0);
        repeat (3) @(negedge clk); #1;
        total++; if (wr_count - base !== 4) begin bad++; $display("FAIL stall_writes: got %0d want 4", wr_count - base); end
        total++; if (credits !== 3'd0) begin bad++; $display("FAIL stall_credits: got %0d want 0", credits); end
        total++; if (row_if.in_ready !== 1'b0 || fifo_wr_en !== 1'b0) begin bad++; $display("FAIL stall_commit: in_ready %b wr_en %b want 0 0", row_if.in_ready, fifo_wr_en); end
        total++; if (fifo_data !== exp_tile(8)) begin bad++; $display("FAIL stall_data: got %h want %h", fifo_data, exp_tile(8)); end
        snap = fifo_data;
        repeat (2) @(negedge clk);
        total++; if (fifo_data !== snap) begin bad++; $display("FAIL stall_stable: got %h want %h", fifo_data, snap); end
        fifo_rd = 1'b1;
        @(negedge clk);
        fifo_rd = 1'b0;
        total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL stall_release_wr: got %b want 1", fifo_wr_en); end
        @(negedge clk); #1;
        total++; if (credits !== 3'd0) begin bad++; $display("FAIL stall_release_credits: got %0d want 0", credits); end
        total++; if (tiles_written !== 16'd5 || wr_count - base !== 5) begin bad++; $display("FAIL stall_release_tiles: tiles %0d writes %0d want 5 5", tiles_written, wr_count - base); end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        fifo_rd = 1'b1;
        repeat (2) @(negedge clk);
        fifo_rd = 1'b0;
        total++; if (credits !== 3'd2) begin bad++; $display("FAIL same_setup_credits: got %0d want 2", credits); end
        for (int r = 0; r < 8; r++) send_row(r, 1'b0);
        fifo_rd = 1'b1;
        @(negedge clk);
        total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL same_wr: got %b want 1", fifo_wr_en); end
        @(negedge clk);
        fifo_rd = 1'b0;
        #1;
        total++; if (credits !== 3'd2) begin bad++; $display("FAIL same_cycle_credits: got %0d want 2", credits); end
        total++; if (tiles_written !== 16'd6) begin bad++; $display("FAIL same_tiles: got %0d want 6", tiles_written); end
        fifo_rd = 1'b1;
        repeat (2) @(negedge clk);
        fifo_rd = 1'b0;
        total++; if (credits !== 3'd4) begin bad++; $display("FAIL refill_credits: got %0d want 4", credits); end
        fifo_rd = 1'b1;
        @(negedge clk);
        fifo_rd = 1'b0;
        @(negedge clk);
        total++; if (credits !== 3'd4) begin bad++; $display("FAIL full_credit_rd: got %0d want 4", credits); end
    endtask

    task automatic test_gaps();
        int base;
        base = wr_count;
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            send_row(r, 1'b0);
        end
        @(negedge clk);
        total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL gaps_wr: got %b want 1", fifo_wr_en); end
        total++; if (fifo_data !== exp_tile(8)) begin bad++; $display("FAIL gaps_data: got %h want %h", fifo_data, exp_tile(8)); end
        repeat (3) @(negedge clk); #1;
        total++; if (wr_count - base !== 1) begin bad++; $display("FAIL gaps_writes: got %0d want 1", wr_count - base); end
    endtask

    task automatic test_mid_reset();
        int base;
        base = wr_count;
        for (int r = 0; r < 5; r++) send_row(r, 1'b0);
        @(negedge clk);
        total++; if (fifo_data !== exp_tile(5)) begin bad++; $display("FAIL partial_visible: got %h want %h", fifo_data, exp_tile(5)); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (fifo_data !== 512'd0 || row_if.in_ready !== 1'b1 || fifo_wr_en !== 1'b0) begin bad++; $display("FAIL midrst_outputs: data %h ready %b wr %b want 0 1 0", fifo_data, row_if.in_ready, fifo_wr_en); end
        total++; if (credits !== 3'd4 || tiles_written !== 16'd0) begin bad++; $display("FAIL midrst_counters: credits %0d tiles %0d want 4 0", credits, tiles_written); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 8; r++) send_row(r, 1'b0);
        @(negedge clk);
        total++; if (fifo_wr_en !== 1'b1 || fifo_data !== exp_tile(8)) begin bad++; $display("FAIL midrst_clean_tile: wr %b data %h want 1 %h", fifo_wr_en, fifo_data, exp_tile(8)); end
        @(negedge clk); #1;
        total++; if (wr_count - base !== 1) begin bad++; $display("FAIL midrst_writes: got %0d want 1", wr_count - base); end
    endtask

    task automatic test_partial();
        int base;
        base = wr_count;
        send_row(0, 1'b0);
        send_row(1, 1'b0);
        send_row(2, 1'b1);
`ifdef WEIGHT_TILE_LOADER_PARTIAL_EN
        @(negedge clk);
        total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL partial_wr: got %b want 1", fifo_wr_en); end
        total++; if (fifo_data !== exp_tile(3)) begin bad++; $display("FAIL partial_data: got %h want %h", fifo_data, exp_tile(3)); end
        @(negedge clk); #1;
        total++; if (wr_count - base !== 1) begin bad++; $display("FAIL partial_writes: got %0d want 1", wr_count - base); end
`else
        repeat (4) @(negedge clk); #1;
        total++; if (wr_count - base !== 0 || row_if.in_ready !== 1'b1) begin bad++; $display("FAIL nolast_hold: writes %0d ready %b want 0 1", wr_count - base, row_if.in_ready); end
        for (int r = 3; r < 8; r++) send_row(r, 1'b0);
        @(negedge clk);
        total++; if (fifo_wr_en !== 1'b1 || fifo_data !== exp_tile(8)) begin bad++; $display("FAIL nolast_tile: wr %b data %h want 1 %h", fifo_wr_en, fifo_data, exp_tile(8)); end
`endif
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        wr_count = 0;
        test_reset();
        test_single_tile();
        test_credit_stall();
        test_same_cycle();
        test_gaps();
        test_mid_reset();
        test_partial();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
